// File: rtl/arcade_input_cond_pkg.sv
// Shared constants for the arcade input conditioner: button bit map, coin FSM states
// and the fixed PS/2 scan-code table for player 0.
package arcade_input_pkg;

    localparam int unsigned BTN_R        = 0;
    localparam int unsigned BTN_L        = 1;
    localparam int unsigned BTN_D        = 2;
    localparam int unsigned BTN_U        = 3;
    localparam int unsigned BTN_F1       = 4;
    localparam int unsigned BTN_F2       = 5;
    localparam int unsigned BTN_F3       = 6;
    localparam int unsigned BTN_F4       = 7;
    localparam int unsigned BTN_S1       = 8;
    localparam int unsigned BTN_S2       = 9;
    localparam int unsigned BTN_COIN     = 10;
    localparam int unsigned NUM_STD_BTNS = 11;

    typedef enum logic [1:0] {
        COIN_IDLE  = 2'd0,
        COIN_PULSE = 2'd1,
        COIN_GAP   = 2'd2
    } coin_state_e;

    localparam logic [7:0] PS2_U      = 8'h75;
    localparam logic [7:0] PS2_D      = 8'h72;
    localparam logic [7:0] PS2_L      = 8'h6B;
    localparam logic [7:0] PS2_R      = 8'h74;
    localparam logic [7:0] PS2_F1     = 8'h14;
    localparam logic [7:0] PS2_F2     = 8'h11;
    localparam logic [7:0] PS2_F3     = 8'h29;
    localparam logic [7:0] PS2_F4     = 8'h12;
    localparam logic [7:0] PS2_S1_A   = 8'h05;
    localparam logic [7:0] PS2_S1_B   = 8'h16;
    localparam logic [7:0] PS2_S2_A   = 8'h06;
    localparam logic [7:0] PS2_S2_B   = 8'h1E;
    localparam logic [7:0] PS2_COIN_A = 8'h2E;
    localparam logic [7:0] PS2_COIN_B = 8'h36;

    // One-hot button mask for a scan code; unknown codes map to nothing.
    function automatic logic [NUM_STD_BTNS-1:0] ps2_decode(input logic [7:0] code);
        logic [NUM_STD_BTNS-1:0] hit;
        hit = '0;
        case (code)
            PS2_U:                  hit[BTN_U]    = 1'b1;
            PS2_D:                  hit[BTN_D]    = 1'b1;
            PS2_L:                  hit[BTN_L]    = 1'b1;
            PS2_R:                  hit[BTN_R]    = 1'b1;
            PS2_F1:                 hit[BTN_F1]   = 1'b1;
            PS2_F2:                 hit[BTN_F2]   = 1'b1;
            PS2_F3:                 hit[BTN_F3]   = 1'b1;
            PS2_F4:                 hit[BTN_F4]   = 1'b1;
            PS2_S1_A, PS2_S1_B:     hit[BTN_S1]   = 1'b1;
            PS2_S2_A, PS2_S2_B:     hit[BTN_S2]   = 1'b1;
            PS2_COIN_A, PS2_COIN_B: hit[BTN_COIN] = 1'b1;
            default:                hit           = '0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/arcade_input_cond_if.sv
// Source-side and core-side signal bundle of the arcade input conditioner.
interface arcade_input_cond_if #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned NUM_BTNS    = 11
);
    logic [10:0]                     ps2_key;
    logic [NUM_PLAYERS*16-1:0]       joy_usb;
    logic [NUM_PLAYERS*16-1:0]       joy_ext;
    logic [NUM_PLAYERS-1:0]          ext_ena;
    logic                            merge_p1;
    logic [3:0]                      autofire_mask;
    logic [NUM_PLAYERS*NUM_BTNS-1:0] btn_l;
    logic [NUM_PLAYERS-1:0]          coin_l;
    logic [NUM_PLAYERS*8-1:0]        coin_count;

    modport master (
        output ps2_key, joy_usb, joy_ext, ext_ena, merge_p1, autofire_mask,
        input  btn_l, coin_l, coin_count
    );

    modport slave (
        input  ps2_key, joy_usb, joy_ext, ext_ena, merge_p1, autofire_mask,
        output btn_l, coin_l, coin_count
    );
endinterface

// File: rtl/arcade_input_cond_debounce.sv
// Single-bit debouncer: the output follows raw only after DEB_CYC stable cycles.
// Output is held active-low so it can drive a core input pin directly.
module input_debounce #(
    parameter int unsigned DEB_CYC = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic deb_l
);
    localparam int unsigned CW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC);

    logic          raw_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
            cnt   <= '0;
            deb_l <= 1'b1;
        end else begin
            raw_q <= raw;
            if (raw_q == ~deb_l) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                deb_l <= ~raw_q;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/arcade_input_cond.sv
// Per-player arcade input conditioner: source select, keyboard merge, debounce and coin shaping.
// Optional autofire gating on fire buttons is enabled by defining AUTOFIRE_EN.
module arcade_input_cond
    import arcade_input_pkg::*;
#(
    parameter int unsigned NUM_PLAYERS    = 2,
    parameter int unsigned NUM_BTNS       = 11,
    parameter int unsigned DEB_CYC        = 1024,
    parameter int unsigned COIN_PULSE_CYC = 250000,
    parameter int unsigned COIN_GAP_CYC   = 250000,
    parameter int unsigned AUTOFIRE_CYC   = 2000000
) (
    input  logic                clk_sys,
    input  logic                RESET_L,
    arcade_input_cond_if.slave  io
);
    localparam int unsigned NB   = NUM_BTNS;
    localparam int unsigned CMAX = (COIN_PULSE_CYC > COIN_GAP_CYC) ? COIN_PULSE_CYC : COIN_GAP_CYC;
    localparam int unsigned CCW  = (CMAX < 2) ? 1 : $clog2(CMAX);

    logic                        ps2_tog_q;
    logic [NUM_STD_BTNS-1:0]     kb_lat;
    logic [NUM_STD_BTNS-1:0]     kb_hit;
    logic [NUM_PLAYERS*NB-1:0]   raw_sel;
    logic [NUM_PLAYERS*NB-1:0]   raw_vec;
    logic [NB-1:0]               raw_or;
    logic [NUM_PLAYERS*NB-1:0]   deb_l;
    logic [NUM_PLAYERS-1:0]      coin_l_q;

    // Keyboard: each toggle of ps2_key[10] is one make/break event for the mapped button.
    assign kb_hit = ps2_decode(io.ps2_key[7:0]);

    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            ps2_tog_q <= 1'b0;
            kb_lat    <= '0;
        end else begin
            ps2_tog_q <= io.ps2_key[10];
            if (io.ps2_key[10] != ps2_tog_q)
                kb_lat <= io.ps2_key[9] ? (kb_lat | kb_hit) : (kb_lat & ~kb_hit);
        end
    end

    // Raw select per player; keyboard joins player 0, optional merge of all players into player 0.
    always_comb begin
        raw_sel = '0;
        raw_or  = '0;
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            raw_sel[p*NB +: NB] = io.ext_ena[p] ? io.joy_ext[16*p +: NB] : io.joy_usb[16*p +: NB];
            if (p == 0)
                raw_sel[0 +: NB] = raw_sel[0 +: NB] | NB'(kb_lat);
            raw_or = raw_or | raw_sel[p*NB +: NB];
        end
        raw_vec = raw_sel;
        if (io.merge_p1)
            raw_vec[0 +: NB] = raw_or;
    end

    for (genvar i = 0; i < int'(NUM_PLAYERS*NB); i++) begin : g_deb
        input_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk   (clk_sys),
            .rst_n (RESET_L),
            .raw   (raw_vec[i]),
            .deb_l (deb_l[i])
        );
    end

`ifdef AUTOFIRE_EN
    localparam int unsigned AFW = (AUTOFIRE_CYC < 2) ? 1 : $clog2(AUTOFIRE_CYC);
    logic           af_phase;
    logic [AFW-1:0] af_cnt;
    logic           af_held;

    always_comb begin
        af_held = 1'b0;
        for (int p = 0; p < int'(NUM_PLAYERS); p++)
            for (int f = 0; f < 4; f++)
                af_held = af_held | (io.autofire_mask[f] & ~deb_l[p*NB + BTN_F1 + f]);
    end

    // Phase restarts high on release so a fresh press fires immediately.
    always_ff @(posedge clk_sys or negedge RESET_L) begin
        if (!RESET_L) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (!af_held) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (af_cnt == AFW'(AUTOFIRE_CYC - 1)) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + AFW'(1);
        end
    end
`else
    logic unused_af;
    assign unused_af = ^io.autofire_mask;
`endif

    logic unused_in;
    assign unused_in = ^{io.ps2_key[8], io.joy_usb, io.joy_ext};

    always_comb begin
        io.btn_l = deb_l;
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
`ifdef AUTOFIRE_EN
            for (int f = 0; f < 4; f++)
                io.btn_l[p*NB + BTN_F1 + f] = deb_l[p*NB + BTN_F1 + f] | (io.autofire_mask[f] & ~af_phase);
`endif
            io.btn_l[p*NB + BTN_COIN] = coin_l_q[p];
        end
    end

    assign io.coin_l = coin_l_q;

    for (genvar p = 0; p < int'(NUM_PLAYERS); p++) begin : g_coin
        coin_state_e    state, state_nxt;
        logic [CCW-1:0] cnt, cnt_nxt;
        logic           pend, pend_nxt;
        logic           prev, coin_l_r, coin_l_nxt, inc_c;
        logic [7:0]     count;
        logic           coin_deb, rise;

        assign coin_deb = ~deb_l[p*NB + BTN_COIN];
        assign rise     = coin_deb & ~prev;

        always_ff @(posedge clk_sys or negedge RESET_L) begin
            if (!RESET_L) begin
                state    <= COIN_IDLE;
                cnt      <= '0;
                pend     <= 1'b0;
                prev     <= 1'b0;
                coin_l_r <= 1'b1;
                count    <= '0;
            end else begin
                state    <= state_nxt;
                cnt      <= cnt_nxt;
                pend     <= pend_nxt;
                prev     <= coin_deb;
                coin_l_r <= coin_l_nxt;
                if (inc_c)
                    count <= count + 8'd1;
            end
        end

        // Edges arriving while busy are remembered once and replayed after the gap.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            pend_nxt  = pend;
            case (state)
                COIN_IDLE: begin
                    cnt_nxt = '0;
                    if (rise)
                        state_nxt = COIN_PULSE;
                end
                COIN_PULSE: begin
                    if (rise)
                        pend_nxt = 1'b1;
                    if (cnt == CCW'(COIN_PULSE_CYC - 1)) begin
                        state_nxt = COIN_GAP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CCW'(1);
                    end
                end
                COIN_GAP: begin
                    if (rise)
                        pend_nxt = 1'b1;
                    if (cnt == CCW'(COIN_GAP_CYC - 1)) begin
                        cnt_nxt = '0;
                        if (pend) begin
                            state_nxt = COIN_PULSE;
                            pend_nxt  = 1'b0;
                        end else begin
                            state_nxt = COIN_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + CCW'(1);
                    end
                end
                default: state_nxt = COIN_IDLE;
            endcase
        end

        always_comb begin
            coin_l_nxt = (state_nxt != COIN_PULSE);
            inc_c      = (state_nxt == COIN_PULSE) && (state != COIN_PULSE);
        end

        assign coin_l_q[p]              = coin_l_r;
        assign io.coin_count[8*p +: 8]  = count;
    end
endmodule

// File: tb/tb_arcade_input_cond.sv
// Directed bench for arcade_input_cond: vector table for source selection plus
// hand-written sequences for reset, debounce, keyboard, coin shaping and autofire.
module tb_arcade_input_cond;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arcade_input_cond_if #(.NUM_PLAYERS(2), .NUM_BTNS(11)) bus  ();
    arcade_input_cond_if #(.NUM_PLAYERS(2), .NUM_BTNS(11)) bus2 ();

    arcade_input_cond #(
        .NUM_PLAYERS(2), .NUM_BTNS(11), .DEB_CYC(8),
        .COIN_PULSE_CYC(10), .COIN_GAP_CYC(5), .AUTOFIRE_CYC(4)
    ) u_dut (
        .clk_sys (clk),
        .RESET_L (rst_n),
        .io      (bus)
    );

    arcade_input_cond #(
        .NUM_PLAYERS(2), .NUM_BTNS(11), .DEB_CYC(2),
        .COIN_PULSE_CYC(10), .COIN_GAP_CYC(5), .AUTOFIRE_CYC(4)
    ) u_coin (
        .clk_sys (clk),
        .RESET_L (rst_n),
        .io      (bus2)
    );

    typedef struct {
        logic [31:0] usb;
        logic [31:0] ext;
        logic [1:0]  ena;
        logic        merge;
        logic [21:0] exp_btn;
    } vec_t;

    vec_t vecs [9];
    int   total = 0;
    int   bad   = 0;
    logic tog   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_btn(input int idx, input logic lvl, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (bus.btn_l[idx] !== lvl && n < 60);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_send(input logic pressed, input logic ext, input logic [7:0] code);
        tog = ~tog;
        bus.ps2_key = {tog, pressed, ext, code};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   n;
        int   mis;
        int   lows;
        int   falls;
        int   pulses;
        int   run;
        int   gap_len;
        int   lo_len [4];
        logic prev_l;
        logic [59:0] hist;

        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 2'b00, 1'b0, 22'h3FFFFF};
        vecs[1] = '{32'h0000_0001, 32'h0000_0000, 2'b00, 1'b0, 22'h3FFFFE};
        vecs[2] = '{32'h0100_0000, 32'h0000_0000, 2'b00, 1'b0, 22'h37FFFF};
        vecs[3] = '{32'h0000_0000, 32'h0100_0000, 2'b10, 1'b0, 22'h37FFFF};
        vecs[4] = '{32'h0100_0000, 32'h0000_0000, 2'b10, 1'b0, 22'h3FFFFF};
        vecs[5] = '{32'h0001_0000, 32'h0000_0000, 2'b00, 1'b1, 22'h3FF7FE};
        vecs[6] = '{32'h0000_0002, 32'h0000_0018, 2'b01, 1'b0, 22'h3FFFE7};
        vecs[7] = '{32'h8000_8000, 32'h0000_0000, 2'b00, 1'b0, 22'h3FFFFF};
        vecs[8] = '{32'h0000_0000, 32'h0200_0000, 2'b10, 1'b1, 22'h2FFDFF};

        bus.ps2_key = '0;  bus.joy_usb = 32'h1;  bus.joy_ext = '0;
        bus.ext_ena = '0;  bus.merge_p1 = 1'b0;  bus.autofire_mask = '0;
        bus2.ps2_key = '0; bus2.joy_usb = '0;    bus2.joy_ext = '0;
        bus2.ext_ena = '0; bus2.merge_p1 = 1'b0; bus2.autofire_mask = '0;
        rst_n = 1'b0;

        // Reset state with a button already held
        repeat (3) @(negedge clk);
        check("reset_btn_l", 64'(bus.btn_l), 64'h3FFFFF);
        check("reset_coin_l", 64'(bus.coin_l), 64'h3);
        check("reset_coin_count", 64'(bus.coin_count), 64'h0);
        rst_n = 1'b1;
        wait_btn(0, 1'b0, n);
        check("reset_release_latency", 64'(n), 64'd9);
        bus.joy_usb = '0;
        wait_btn(0, 1'b1, n);
        check("release_latency", 64'(n), 64'd9);

        // Glitch of 7 cycles must be swallowed
        bus.joy_usb = 32'h8;
        mis = 0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (bus.btn_l[3] !== 1'b1) mis++;
        end
        bus.joy_usb = '0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.btn_l[3] !== 1'b1) mis++;
        end
        check("glitch_7_cycles", 64'(mis), 64'd0);
        bus.joy_usb = 32'h8;
        wait_btn(3, 1'b0, n);
        check("long_press_fall", 64'(n), 64'd9);
        cycles(11);
        bus.joy_usb = '0;
        wait_btn(3, 1'b1, n);
        check("long_press_rise", 64'(n), 64'd9);

        // Source select / merge table
        for (int v = 0; v < 9; v++) begin
            bus.joy_usb  = vecs[v].usb;
            bus.joy_ext  = vecs[v].ext;
            bus.ext_ena  = vecs[v].ena;
            bus.merge_p1 = vecs[v].merge;
            cycles(12);
            check($sformatf("vec%0d", v), 64'(bus.btn_l), 64'(vecs[v].exp_btn));
        end
        bus.joy_usb = '0; bus.joy_ext = '0; bus.ext_ena = '0; bus.merge_p1 = 1'b0;
        cycles(12);

        // Keyboard events
        ps2_send(1'b1, 1'b0, 8'h75);
        cycles(14);
        check("kb_up_press", 64'(bus.btn_l[3]), 64'd0);
        ps2_send(1'b0, 1'b0, 8'h75);
        cycles(14);
        check("kb_up_release", 64'(bus.btn_l[3]), 64'd1);
        bus.ps2_key = {tog, 1'b1, 1'b0, 8'h6B};
        cycles(14);
        check("kb_no_toggle", 64'(bus.btn_l), 64'h3FFFFF);
        ps2_send(1'b1, 1'b0, 8'h1C);
        cycles(14);
        check("kb_unknown_code", 64'(bus.btn_l), 64'h3FFFFF);
        ps2_send(1'b1, 1'b1, 8'h74);
        cycles(14);
        check("kb_ext_flag_ignored", 64'(bus.btn_l), 64'h3FFFFE);
        ps2_send(1'b0, 1'b0, 8'h74);
        cycles(14);
        ps2_send(1'b1, 1'b0, 8'h2E);
        mis = 0; lows = 0; falls = 0; prev_l = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (bus.btn_l[10] !== bus.coin_l[0]) mis++;
            if (bus.coin_l[0] === 1'b0) lows++;
            if (prev_l === 1'b1 && bus.coin_l[0] === 1'b0) falls++;
            prev_l = bus.coin_l[0];
        end
        check("kb_coin_pulses", 64'(falls), 64'd1);
        check("kb_coin_low_cycles", 64'(lows), 64'd10);
        check("kb_coin_btn_bit", 64'(mis), 64'd0);
        ps2_send(1'b0, 1'b0, 8'h2E);
        cycles(20);
        check("kb_coin_count", 64'(bus.coin_count), 64'h0001);

        // Coin shaping: three rising edges close together give two pulses
        fork
            begin
                for (int k = 0; k < 3; k++) begin
                    bus2.joy_usb = 32'h400;
                    cycles(3);
                    bus2.joy_usb = '0;
                    cycles(3);
                end
            end
            begin
                mis = 0;
                for (int i = 0; i < 60; i++) begin
                    @(posedge clk); #1;
                    hist[i] = bus2.coin_l[0];
                    if (bus2.btn_l[10] !== bus2.coin_l[0]) mis++;
                end
            end
        join
        pulses = 0; run = 0; gap_len = 0; prev_l = 1'b1;
        for (int i = 0; i < 4; i++) lo_len[i] = 0;
        for (int i = 0; i < 60; i++) begin
            if (hist[i] == 1'b0) begin
                if (prev_l) begin
                    if (pulses == 1) gap_len = run;
                    pulses++;
                    run = 0;
                end
                run++;
                if (pulses <= 4) lo_len[pulses-1] = run;
            end else begin
                if (!prev_l) run = 0;
                run++;
            end
            prev_l = hist[i];
        end
        check("coin_pulse_count", 64'(pulses), 64'd2);
        check("coin_pulse0_len", 64'(lo_len[0]), 64'd10);
        check("coin_pulse1_len", 64'(lo_len[1]), 64'd10);
        check("coin_gap_len", 64'(gap_len), 64'd5);
        check("coin_count_two", 64'(bus2.coin_count), 64'h0002);
        check("coin_btn_bit", 64'(mis), 64'd0);

        // Reset in the middle of a pulse with a coin pending
        bus.ps2_key = '0; tog = 1'b0;
        bus2.joy_usb = 32'h400; cycles(3);
        bus2.joy_usb = '0;      cycles(3);
        bus2.joy_usb = 32'h400; cycles(3);
        bus2.joy_usb = '0;      cycles(3);
        check("mid_pulse_low", 64'(bus2.coin_l[0]), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_pulse_reset_coin_l", 64'(bus2.coin_l), 64'h3);
        check("mid_pulse_reset_count", 64'(bus2.coin_count), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mis = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus2.coin_l[0] !== 1'b1) mis++;
        end
        check("pending_lost_after_reset", 64'(mis), 64'd0);

        // Autofire on fire1
        bus.autofire_mask = 4'b0001;
        bus.joy_usb = 32'h10;
        wait_btn(4, 1'b0, n);
        check("fire1_press_latency", 64'(n), 64'd9);
        for (int i = 1; i < 16; i++) begin
            @(posedge clk); #1;
`ifdef AUTOFIRE_EN
            check($sformatf("autofire_i%0d", i), 64'(bus.btn_l[4]), 64'((i / 4) % 2));
`else
            check($sformatf("fire_steady_i%0d", i), 64'(bus.btn_l[4]), 64'd0);
`endif
        end
        bus.joy_usb = '0;
        cycles(12);
        bus.autofire_mask = 4'b0000;
        bus.joy_usb = 32'h10;
        cycles(12);
        mis = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus.btn_l[4] !== 1'b0) mis++;
        end
        check("fire_mask0_steady", 64'(mis), 64'd0);
        bus.joy_usb = '0;
        cycles(12);
        check("final_idle", 64'(bus.btn_l), 64'h3FFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Parametrised per-player input conditioner for arcade cores, placed between hps_io/DB9/DB15 joystick sources and the game core's active-low input ports.
- Merges USB joystick, external UserIO joystick and PS/2 keyboard.
- Debounces every button and converts coin presses into fixed-width, rate-limited coin-mech pulses.
- Produces active-low button vectors plus a coin event counter per player.

Parameters:
- NUM_PLAYERS, 2, number of player channels (1..4).
- NUM_BTNS, 11, buttons per player. Bit order: 0 R, 1 L, 2 D, 3 U, 4..7 fire1..4, 8 start1, 9 start2, 10 coin, rest pass-through (>=11).
- DEB_CYC, 1024, clock cycles an input must be stable before the debounced value changes (>=2).
- COIN_PULSE_CYC, 250000, coin_l low time in cycles.
- COIN_GAP_CYC, 250000, minimum high time between coin pulses.
- AUTOFIRE_CYC, 2000000, autofire half-period (used only with the macro).

Ports:
- clk_sys  in  1  system clock.
- RESET_L  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] toggle strobe, [9] pressed, [7:0] scan code.
- joy_usb  in  NUM_PLAYERS*16  USB joystick words, player p at [16p+15:16p], active-high.
- joy_ext  in  NUM_PLAYERS*16  DB9/DB15 words, same layout.
- ext_ena  in  NUM_PLAYERS  1 = player p takes joy_ext instead of joy_usb.
- merge_p1  in  1  1 = player 0 raw input is the OR of all players' raw inputs.
- autofire_mask  in  4  per-fire-button autofire enable.
- btn_l  out  NUM_PLAYERS*NUM_BTNS  debounced buttons, active-low, coin bit replaced by pulse.
- coin_l  out  NUM_PLAYERS  shaped coin pulse, active-low.
- coin_count  out  NUM_PLAYERS*8  accepted coin pulses per player, wraps 255->0.

Behaviour:
- Reset (async assert, sync release): all btn_l and coin_l = 1; coin_count = 0; debounce state = released; keyboard latches = 0; coin FSMs = IDLE with no pending coin.
- Keyboard:
  - A ps2_key[10] level differing from its previous registered value is one event. Latch bit <= ps2_key[9].
  - Fixed code table, player 0 only: 75 U, 72 D, 6B L, 74 R, 14 F1, 11 F2, 29 F3, 12 F4, 05/16 S1, 06/1E S2, 2E/36 coin.
  - Other codes are ignored. ps2_key[8] (extended) is ignored.
- Raw per player: (ext_ena[p] ? joy_ext : joy_usb)[NUM_BTNS-1:0], OR'd with keyboard latches for p=0. With merge_p1=1, player 0 raw = OR of all players' raw.
- Debounce, per bit:
  - Registered raw feeds a counter. The counter resets when raw equals the debounced value, otherwise increments.
  - On reaching DEB_CYC-1, debounced <= raw and the counter clears.
  - Latency from stable change to output: DEB_CYC+1 cycles.
  - Glitches shorter than DEB_CYC produce no output change.
- Coin FSM per player, states IDLE, PULSE, GAP:
  - IDLE: on a debounced coin rising edge -> PULSE, coin_l=0, coin_count+1 in the same cycle.
  - PULSE: exits after COIN_PULSE_CYC cycles -> GAP, coin_l=1.
  - GAP: exits after COIN_GAP_CYC cycles -> IDLE, or straight to PULSE if pending (pending cleared, count+1).
  - A rising edge during PULSE/GAP sets pending. One pending maximum; further edges are dropped.
  - Holding coin produces exactly one pulse.
  - btn_l coin bit = coin_l.
- Reset mid-pulse: coin_l returns to 1 immediately; the pending coin is lost.
- Simultaneous keyboard event and joystick change: both are applied in the same cycle (OR).

Optional Feature:
- AUTOFIRE_EN defined:
  - A free-running counter toggles a phase every AUTOFIRE_CYC cycles.
  - Fire bit i (4..7) with autofire_mask[i-4]=1 is gated (debounced AND phase) while held.
  - The phase counter restarts when all masked fires are released.
- Undefined: autofire_mask is ignored; fire bits equal the debounced value.

Decomposition:
- Package arcade_input_pkg: button index constants (BTN_R..BTN_COIN), coin FSM state enum, PS/2 code table constants.
- One sub-module, input_debounce: single-bit debouncer parametrised by DEB_CYC, instantiated NUM_PLAYERS*NUM_BTNS times. The coin FSM stays inline.

Test Plan:
- Reset: RESET_L=0 with joy_usb bit0 held -> btn_l all ones, coin_l=1, coin_count=0; release -> btn_l[0] falls at DEB_CYC+1 cycles (DEB_CYC=8: cycle 9).
- Glitch: DEB_CYC=8, USB bit3 high 7 cycles -> btn_l unchanged; high 20 cycles -> falls after 9 cycles and rises 9 cycles after release.
- Keyboard: ps2_key toggle with code 75 pressed -> player0 U low after debounce; toggle with code 75 released -> high; code 2E -> one coin pulse. Unchanged ps2_key[10] -> no action.
- Coin shaping: PULSE=10, GAP=5, three edges 3 cycles apart -> exactly two pulses, each 10 cycles low, separated by 5 high; coin_count=2.
- Source select: ext_ena=2'b10, player1 ext bit8 set -> p1 start1 low; the same bit in joy_usb p1 -> no effect. merge_p1=1 with player1 R -> player0 R also low.
- AUTOFIRE_EN, AUTOFIRE_CYC=4, mask=0001, F1 held -> btn_l F1 toggles every 4 cycles. mask=0 -> steady low.
